// File: rtl/wi_mac_neuron_pkg.sv
// Shared constants, state encoding and MAC arithmetic helper for the
// neuron datapath that sits behind the weight ROM Wi.
package wi_nn_pkg;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int ACCW = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Unsigned DW x DW product, zero-extended and added; wraps modulo 2^ACCW.
  function automatic logic [ACCW-1:0] mac_step(input logic [ACCW-1:0] acc,
                                               input logic [DW-1:0]   x,
                                               input logic [DW-1:0]   w);
    logic [2*DW-1:0] prod;
    prod = x * w;
    return acc + ACCW'(prod);
  endfunction

endpackage

// File: rtl/wi_mac_neuron_if.sv
// Control, feature-input and result handshake bundle of the neuron stage.
interface wi_mac_neuron_if;
  import wi_nn_pkg::*;

  logic            start;
  logic [AW-1:0]   base_addr;
  logic [DW-1:0]   x_in;
  logic            x_valid;
  logic            x_ready;
  logic [ACCW-1:0] y_out;
  logic            y_valid;
  logic            y_ready;
  logic            busy;

  modport master (
    output start, base_addr, x_in, x_valid, y_ready,
    input  x_ready, y_out, y_valid, busy
  );

  modport slave (
    input  start, base_addr, x_in, x_valid, y_ready,
    output x_ready, y_out, y_valid, busy
  );

endinterface

// File: rtl/wi_mac_neuron.sv
// Neuron MAC stage: walks the weight row in Wi, multiplies each feature
// sample by the registered weight Wip and accumulates N_TAPS products.
// Each tap spends one FETCH cycle so Wi can register ROM[add] before use.
module wi_mac_neuron
  import wi_nn_pkg::*;
#(
  parameter int N_TAPS = 256
) (
  input  logic            CS,
  input  logic            cen,
  wi_mac_neuron_if.slave  nif,
  output logic [AW-1:0]   add,
  input  logic [DW-1:0]   Wip
);

  localparam int            CW       = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(N_TAPS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   add_q, add_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [ACCW-1:0] y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ACCW-1:0] acc_sum;

  // State and datapath registers; reset clears everything including the sum.
  always_ff @(posedge CS) begin
    if (!cen) begin
      state_q <= IDLE;
      add_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; every register holds unless a state acts.
  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    acc_d   = acc_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    acc_sum = mac_step(acc_q, nif.x_in, Wip);
    unique case (state_q)
      IDLE: begin
        if (nif.start) begin
          add_d   = nif.base_addr;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = MAC;
      end
      MAC: begin
        if (nif.x_valid) begin
          acc_d = acc_sum;
          if (cnt_q == LAST_TAP) begin
            y_d     = acc_sum;
            state_d = OUT;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            add_d   = add_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      OUT: begin
        if (nif.y_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  assign nif.x_ready = (state_q == MAC);
  assign nif.y_valid = (state_q == OUT);
  assign nif.busy    = (state_q != IDLE);
  assign nif.y_out   = y_q;
  assign add         = add_q;

endmodule
